// File: rtl/eth_tx_framer.sv
// GMII transmit framer: buffered payload out as preamble, SFD, data, pad, FCS, then IPG.
// Host loads a 32-bit word buffer, then pulses i_start with the payload byte length.
module eth_tx_framer #(
    parameter int unsigned BUF_AW  = 6,
    parameter bit          PAD_EN  = 1'b1,
    parameter int unsigned IPG_LEN = 12
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_tx_wr,
    input  logic [BUF_AW-1:0] i_tx_wr_addr,
    input  logic [31:0]       i_tx_wr_data,
    input  logic              i_start,
    input  logic [10:0]       i_len,
    output logic              o_busy,
    output logic              o_irq_tx,
    output logic              o_err,
    output logic              o_tx_en,
    output logic [7:0]        o_tx_data
);

    localparam int unsigned BUF_WORDS = 1 << BUF_AW;
    localparam int unsigned BUF_BYTES = 4 * BUF_WORDS;
    localparam int unsigned MIN_LEN   = 60;
    localparam int unsigned CNT_W     = 11;

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_SFD, S_DATA, S_PAD, S_FCS, S_IPG
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [10:0]        idx_q, idx_d;
    logic [10:0]        len_q, len_d;
    logic [31:0]        crc_q, crc_d;
    logic               busy_q, busy_d;
    logic               irq_q, irq_d;
    logic               err_q, err_d;
    logic               tx_en_q, tx_en_d;
    logic [7:0]         tx_data_q, tx_data_d;

    logic [31:0]        buf_mem [BUF_WORDS];
    logic [31:0]        rd_word_q;
    logic [BUF_AW-1:0]  rd_addr_c;
    logic [7:0]         rd_byte_c;
    logic [31:0]        fcs_c;
    logic               len_bad_c;
    logic               pad_needed_c;

    // Reflected CRC32 update by one byte, LSB first
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    function automatic logic [7:0] fcs_byte(input logic [31:0] f, input logic [1:0] k);
        logic [7:0] r;
        case (k)
            2'd0:    r = f[7:0];
            2'd1:    r = f[15:8];
            2'd2:    r = f[23:16];
            default: r = f[31:24];
        endcase
        return r;
    endfunction

    // Word buffer; read address follows the next byte index so the word is ready one cycle ahead
    always_ff @(posedge i_clk) begin
        if (i_tx_wr) begin
            buf_mem[i_tx_wr_addr] <= i_tx_wr_data;
        end
        rd_word_q <= buf_mem[rd_addr_c];
    end

    assign rd_addr_c    = idx_d[BUF_AW+1:2];
    assign fcs_c        = ~crc_q;
    assign len_bad_c    = (i_len == 11'd0) || (32'(i_len) > BUF_BYTES);
    assign pad_needed_c = PAD_EN && (len_q < 11'(MIN_LEN));

    always_comb begin
        case (idx_q[1:0])
            2'd0:    rd_byte_c = rd_word_q[7:0];
            2'd1:    rd_byte_c = rd_word_q[15:8];
            2'd2:    rd_byte_c = rd_word_q[23:16];
            default: rd_byte_c = rd_word_q[31:24];
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            len_q     <= '0;
            crc_q     <= 32'hFFFFFFFF;
            busy_q    <= 1'b0;
            irq_q     <= 1'b0;
            err_q     <= 1'b0;
            tx_en_q   <= 1'b0;
            tx_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            crc_q     <= crc_d;
            busy_q    <= busy_d;
            irq_q     <= irq_d;
            err_q     <= err_d;
            tx_en_q   <= tx_en_d;
            tx_data_q <= tx_data_d;
        end
    end

    // Next state and the byte that will be on the wire after the coming edge
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        len_d     = len_q;
        crc_d     = crc_q;
        busy_d    = busy_q;
        irq_d     = 1'b0;
        err_d     = 1'b0;
        tx_en_d   = 1'b0;
        tx_data_d = 8'h00;

        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    if (len_bad_c) begin
                        err_d = 1'b1;
                    end else begin
                        state_d   = S_PRE;
                        cnt_d     = '0;
                        idx_d     = '0;
                        len_d     = i_len;
                        crc_d     = 32'hFFFFFFFF;
                        busy_d    = 1'b1;
                        tx_en_d   = 1'b1;
                        tx_data_d = 8'h55;
                    end
                end
            end
            S_PRE: begin
                tx_en_d = 1'b1;
                if (cnt_q == CNT_W'(6)) begin
                    state_d   = S_SFD;
                    tx_data_d = 8'hD5;
                end else begin
                    cnt_d     = cnt_q + CNT_W'(1);
                    tx_data_d = 8'h55;
                end
            end
            S_SFD, S_DATA: begin
                tx_en_d = 1'b1;
                if ((state_q == S_DATA) && (idx_q == len_q)) begin
                    if (pad_needed_c) begin
                        state_d = S_PAD;
                        crc_d   = crc_byte(crc_q, 8'h00);
                        idx_d   = idx_q + 11'd1;
                    end else begin
                        state_d   = S_FCS;
                        cnt_d     = '0;
                        tx_data_d = fcs_c[7:0];
                    end
                end else begin
                    state_d   = S_DATA;
                    tx_data_d = rd_byte_c;
                    crc_d     = crc_byte(crc_q, rd_byte_c);
                    idx_d     = idx_q + 11'd1;
                end
            end
            S_PAD: begin
                tx_en_d = 1'b1;
                if (idx_q == 11'(MIN_LEN)) begin
                    state_d   = S_FCS;
                    cnt_d     = '0;
                    tx_data_d = fcs_c[7:0];
                end else begin
                    crc_d = crc_byte(crc_q, 8'h00);
                    idx_d = idx_q + 11'd1;
                end
            end
            S_FCS: begin
                if (cnt_q == CNT_W'(3)) begin
                    state_d = S_IPG;
                    cnt_d   = '0;
                end else begin
                    tx_en_d   = 1'b1;
                    cnt_d     = cnt_q + CNT_W'(1);
                    tx_data_d = fcs_byte(fcs_c, 2'(cnt_q + CNT_W'(1)));
                end
            end
            S_IPG: begin
                if (cnt_q == CNT_W'(IPG_LEN - 1)) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    irq_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_busy    = busy_q;
    assign o_irq_tx  = irq_q;
    assign o_err     = err_q;
    assign o_tx_en   = tx_en_q;
    assign o_tx_data = tx_data_q;

endmodule
